freq_meas: RTL and testbench

Measures the period and high time of a slow square wave, in `clk_in` cycles. A typical source is the output of the divider elsewhere in this design. It recovers the division factor and duty cycle, and flags when the measurement is stable across consecutive periods. Used as the checker/monitor end of the divider chain: on-chip self-test of divided clocks and ratio detection of externally supplied slow clocks.

---
 rtl/freq_meas_pkg.sv | 21 ++
 rtl/freq_meas_sync.sv | 34 +++
 rtl/freq_meas.sv | 120 ++++++++++++
 tb/tb_freq_meas.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the slow-clock period/high-time monitor.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } meas_state_t;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  // Illegal depths are pulled back into range rather than building a broken chain
  function automatic int sync_depth(input int n);
    if (n < SYNC_MIN) return SYNC_MIN;
    if (n > SYNC_MAX) return SYNC_MAX;
    return n;
  endfunction

endpackage

// File: rtl/freq_meas_sync.sv
// Input synchronizer for the measured signal, with one-cycle rise/fall strobes.
module sync_edge_det
  import freq_meas_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  localparam int STAGES = sync_depth(SYNC_STAGES);

  logic [STAGES-1:0] sync_q;
  logic              sig_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_in};
      sig_d  <= sync_q[STAGES-1];
    end
  end

  assign sig_s = sync_q[STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/freq_meas.sv
// Measures period and high time of a slow square wave in clk_in cycles,
// flags repeatable measurements and counter saturation.
module freq_meas
  import freq_meas_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             stable,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meas_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, hcap;
  logic             sig_s, rise, fall;
  logic             counting, capture, complete, saturate;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!meas_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = ARM;
        ARM:       if (rise) state_next = MEAS_HIGH;
        MEAS_HIGH: if (saturate) state_next = ARM;
                   else if (fall) state_next = MEAS_LOW;
        MEAS_LOW:  if (saturate) state_next = ARM;
                   else if (rise) state_next = MEAS_HIGH;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Saturation wins over a fall arriving at the all-ones count so cnt never wraps
  always_comb begin
    counting = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    saturate = 1'b0;
    case (state)
      MEAS_HIGH: begin
        counting = 1'b1;
        saturate = (cnt == CNT_MAX) && !rise;
        capture  = fall && !saturate;
      end
      MEAS_LOW: begin
        counting = 1'b1;
        saturate = (cnt == CNT_MAX) && !rise;
        complete = rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt        <= '0;
      hcap       <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      stable     <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      ovf        <= 1'b0;
      if (!meas_en) begin
        cnt    <= '0;
        hcap   <= '0;
        stable <= 1'b0;
      end else begin
        if (saturate) begin
          cnt    <= '0;
          ovf    <= 1'b1;
          stable <= 1'b0;
        end else if (rise && state != IDLE) begin
          cnt <= CNT_W'(1);
        end else if (counting) begin
          cnt <= cnt + 1'b1;
        end
        if (capture) hcap <= cnt;
        if (complete) begin
          period_out <= cnt;
          high_out   <= hcap;
          meas_valid <= 1'b1;
          stable     <= (cnt == period_out) && (hcap == high_out);
        end
      end
    end
  end

  // Synchronized edges alternate, so MEAS_HIGH only ever sees the input high or falling
  assert property (@(posedge clk_in) disable iff (rst)
    !(state == MEAS_HIGH && (rise || (!sig_s && !fall))));

endmodule

// File: tb/tb_freq_meas.sv
// Self-checking bench for freq_meas: table vectors, corner sequences and
// randomized square waves checked against a rise-to-rise reference model.
module tb_freq_meas;

  localparam int MAXLEN = 256;

  logic        clk_in;
  logic        rst, sig_in, meas_en;
  logic [15:0] period_out, high_out;
  logic        meas_valid, stable, ovf;
  logic [3:0]  period4, high4;
  logic        valid4, stable4, ovf4;

  freq_meas #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .stable(stable), .ovf(ovf)
  );

  freq_meas #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .period_out(period4), .high_out(high4), .meas_valid(valid4),
    .stable(stable4), .ovf(ovf4)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int h;
    int l;
    int nper;
    int exp_period;
    int exp_high;
  } vec_t;

  logic wave_sig [MAXLEN];
  logic wave_en  [MAXLEN];
  logic wave_rst [MAXLEN];
  int   wlen;

  logic obs_valid [MAXLEN];
  logic obs_stable[MAXLEN];
  logic obs_ovf   [MAXLEN];
  int   obs_period[MAXLEN];
  int   obs_high  [MAXLEN];
  logic obs_valid4 [MAXLEN];
  logic obs_stable4[MAXLEN];
  logic obs_ovf4   [MAXLEN];
  int   obs_period4[MAXLEN];

  int pass_count = 0;
  int check_count = 0;
  int m_period = 0;
  int m_high = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_waves();
    wlen = 0;
    for (int i = 0; i < MAXLEN; i++) begin
      wave_sig[i] = 1'b0;
      wave_en[i]  = 1'b1;
      wave_rst[i] = 1'b0;
    end
  endtask

  task automatic add_seg(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (wlen < MAXLEN) begin
        wave_sig[wlen] = v;
        wlen++;
      end
    end
  endtask

  task automatic restart();
    rst = 1'b0;
    meas_en = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic apply_stimulus(input int len);
    for (int j = 0; j < len; j++) begin
      rst = wave_rst[j];
      meas_en = wave_en[j];
      sig_in = wave_sig[j];
      step();
      obs_valid[j]   = meas_valid;
      obs_stable[j]  = stable;
      obs_ovf[j]     = ovf;
      obs_period[j]  = int'(period_out);
      obs_high[j]    = int'(high_out);
      obs_valid4[j]  = valid4;
      obs_stable4[j] = stable4;
      obs_ovf4[j]    = ovf4;
      obs_period4[j] = int'(period4);
    end
  endtask

  // Each rise after the first closes one period; its result shows two edges later
  task automatic check_model(input string tag, input int len);
    int rises[$];
    int exp_count, obs_count, ovf_count, p, h, cyc;
    logic prev, exp_stable;
    exp_count = 0;
    obs_count = 0;
    ovf_count = 0;
    for (int j = 0; j < len; j++) begin
      prev = (j == 0) ? 1'b0 : wave_sig[j-1];
      if (wave_sig[j] && !prev) rises.push_back(j);
      if (obs_valid[j]) obs_count++;
      if (obs_ovf[j]) ovf_count++;
    end
    for (int i = 1; i < rises.size(); i++) begin
      cyc = rises[i] + 2;
      if (cyc >= len) continue;
      p = rises[i] - rises[i-1];
      h = 0;
      for (int t = rises[i-1]; t < rises[i]; t++) h += int'(wave_sig[t]);
      exp_stable = (p == m_period) && (h == m_high);
      m_period = p;
      m_high = h;
      exp_count++;
      check_output($sformatf("%s valid@%0d", tag, cyc), int'(obs_valid[cyc]), 1);
      check_output($sformatf("%s period@%0d", tag, cyc), obs_period[cyc], p);
      check_output($sformatf("%s high@%0d", tag, cyc), obs_high[cyc], h);
      check_output($sformatf("%s stable@%0d", tag, cyc), int'(obs_stable[cyc]), int'(exp_stable));
    end
    check_output($sformatf("%s valid count", tag), obs_count, exp_count);
    check_output($sformatf("%s ovf count", tag), ovf_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[5];
    int n, last, cnt4, ovf4_count;

    vecs[0] = '{h: 2, l: 2, nper: 3, exp_period: 4,  exp_high: 2};
    vecs[1] = '{h: 3, l: 2, nper: 3, exp_period: 5,  exp_high: 3};
    vecs[2] = '{h: 1, l: 1, nper: 3, exp_period: 2,  exp_high: 1};
    vecs[3] = '{h: 1, l: 5, nper: 3, exp_period: 6,  exp_high: 1};
    vecs[4] = '{h: 7, l: 3, nper: 3, exp_period: 10, exp_high: 7};

    rst = 1'b1;
    meas_en = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    check_output("reset period_out", int'(period_out), 0);
    check_output("reset high_out", int'(high_out), 0);
    check_output("reset meas_valid", int'(meas_valid), 0);
    check_output("reset stable", int'(stable), 0);
    check_output("reset ovf", int'(ovf), 0);
    rst = 1'b0;

    // Table: synchronous square waves, fixed ratio per entry
    for (int v = 0; v < 5; v++) begin
      restart();
      clear_waves();
      add_seg(1'b0, 3);
      for (int p = 0; p <= vecs[v].nper; p++) begin
        add_seg(1'b1, vecs[v].h);
        add_seg(1'b0, vecs[v].l);
      end
      add_seg(1'b0, 3);
      apply_stimulus(wlen);
      n = 0;
      last = -1;
      for (int j = 0; j < wlen; j++) begin
        if (obs_valid[j]) begin
          n++;
          check_output($sformatf("vec%0d period", v), obs_period[j], vecs[v].exp_period);
          check_output($sformatf("vec%0d high", v), obs_high[j], vecs[v].exp_high);
          check_output($sformatf("vec%0d stable", v), int'(obs_stable[j]), (n > 1) ? 1 : 0);
          if (last >= 0)
            check_output($sformatf("vec%0d spacing", v), j - last, vecs[v].h + vecs[v].l);
          last = j;
        end
      end
      check_output($sformatf("vec%0d valid count", v), n, vecs[v].nper);
    end
    m_period = 10;
    m_high = 7;

    // Ratio change 4 -> 6 mid-stream
    restart();
    clear_waves();
    add_seg(1'b0, 3);
    repeat (3) begin add_seg(1'b1, 2); add_seg(1'b0, 2); end
    repeat (2) begin add_seg(1'b1, 3); add_seg(1'b0, 3); end
    add_seg(1'b1, 2);
    add_seg(1'b0, 3);
    apply_stimulus(wlen);
    check_model("ratio", wlen);
    check_output("ratio first6 stable", int'(obs_stable[23]), 0);
    check_output("ratio second6 stable", int'(obs_stable[29]), 1);
    check_output("ratio second6 period", obs_period[29], 6);

    // Saturation on the 4-bit instance: input held high after arming
    restart();
    clear_waves();
    add_seg(1'b0, 3);
    repeat (3) begin add_seg(1'b1, 2); add_seg(1'b0, 2); end
    add_seg(1'b1, 25);
    add_seg(1'b0, 3);
    repeat (2) begin add_seg(1'b1, 2); add_seg(1'b0, 2); end
    add_seg(1'b1, 2);
    add_seg(1'b0, 3);
    apply_stimulus(wlen);
    check_model("ovf-main", wlen);
    cnt4 = 0;
    ovf4_count = 0;
    for (int j = 0; j < wlen; j++) begin
      if (obs_valid4[j]) cnt4++;
      if (obs_ovf4[j]) ovf4_count++;
    end
    check_output("ovf4 pulse at cnt max", int'(obs_ovf4[32]), 1);
    check_output("ovf4 pulse count", ovf4_count, 1);
    check_output("ovf4 stable before", int'(obs_stable4[31]), 1);
    check_output("ovf4 stable cleared", int'(obs_stable4[32]), 0);
    check_output("ovf4 period holds", obs_period4[32], 4);
    check_output("ovf4 resume valid", int'(obs_valid4[49]), 1);
    check_output("ovf4 resume period", obs_period4[49], 4);
    check_output("ovf4 valid count", cnt4, 5);

    // meas_en dropped while in MEAS_LOW, edge during disable, then re-enable
    restart();
    clear_waves();
    add_seg(1'b0, 3);
    repeat (2) begin add_seg(1'b1, 2); add_seg(1'b0, 3); end
    add_seg(1'b1, 2);
    add_seg(1'b0, 5);
    add_seg(1'b1, 2);
    add_seg(1'b0, 2);
    repeat (2) begin add_seg(1'b1, 2); add_seg(1'b0, 2); end
    add_seg(1'b1, 2);
    add_seg(1'b0, 3);
    for (int j = 19; j <= 22; j++) wave_en[j] = 1'b0;
    apply_stimulus(wlen);
    n = 0;
    for (int j = 16; j < 30; j++) if (obs_valid[j]) n++;
    check_output("en valid before drop", int'(obs_valid[15]), 1);
    check_output("en period before drop", obs_period[15], 5);
    check_output("en stable before drop", int'(obs_stable[18]), 1);
    check_output("en stable after drop", int'(obs_stable[19]), 0);
    check_output("en period holds", obs_period[21], 5);
    check_output("en high holds", obs_high[21], 2);
    check_output("en no valid while off/rearming", n, 0);
    check_output("en first valid after rearm", int'(obs_valid[30]), 1);
    check_output("en rearm period", obs_period[30], 4);
    check_output("en rearm stable", int'(obs_stable[30]), 0);
    check_output("en second rearm stable", int'(obs_stable[34]), 1);
    m_period = 4;
    m_high = 2;

    // Randomized waveforms against the rise-to-rise model
    for (int trial = 0; trial < 6; trial++) begin
      int h, l;
      h = 0;
      l = 0;
      restart();
      clear_waves();
      add_seg(1'b0, 3);
      for (int s = 0; s < 8; s++) begin
        if (s == 0 || $urandom_range(0, 1) == 0) begin
          h = $urandom_range(1, 6);
          l = $urandom_range(1, 6);
        end
        add_seg(1'b1, h);
        add_seg(1'b0, l);
      end
      add_seg(1'b1, 2);
      add_seg(1'b0, 3);
      apply_stimulus(wlen);
      check_model($sformatf("rand%0d", trial), wlen);
    end

    // Reset landing on the same edge as a completing rise
    restart();
    clear_waves();
    add_seg(1'b0, 3);
    add_seg(1'b1, 2);
    add_seg(1'b0, 2);
    add_seg(1'b1, 2);
    add_seg(1'b0, 3);
    wave_rst[9] = 1'b1;
    apply_stimulus(wlen);
    check_output("rst valid suppressed", int'(obs_valid[9]), 0);
    check_output("rst period cleared", obs_period[9], 0);
    check_output("rst high cleared", obs_high[9], 0);
    check_output("rst stable cleared", int'(obs_stable[9]), 0);
    check_output("rst ovf cleared", int'(obs_ovf[9]), 0);
    check_output("rst period4 cleared", obs_period4[9], 0);
    check_output("rst no late valid", int'(obs_valid[10]) + int'(obs_valid[11]), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
